ext_mem_responder: RTL
======================

Name: ext_mem_responder

Overview:
- Synthesizable off-chip memory responder downstream of the HLS accelerator's master memory port (Mout_*), returning M_Rdata_ram/M_DataRdy.
- Implements a byte-lane memory window at a fixed base address, per-channel configurable read/write latency, and masked partial writes.
- ORs in the accelerator's own slave return path (Sout_*).
- Replaces the behavioural memory model so that co-simulation and FPGA-in-the-loop runs share one RTL responder.

Parameters:
- CHANNELS, 2, number of independent memory channels (lanes).
- ADDR_W, 11, address bits per channel.
- DATA_W, 8, data bits per channel lane.
- SIZE_W, 4, access-size field bits per channel (bit count, 0..DATA_W).
- BASE_ADDR, 256, first byte address served.
- MEMSIZE, 256, number of bytes served; window is [BASE_ADDR, BASE_ADDR+MEMSIZE).
- READ_DELAY, 2, cycles from oe assertion to DataRdy, inclusive; must be >=1.
- WRITE_DELAY, 1, cycles from we assertion to DataRdy, inclusive; must be >=1.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- Mout_oe_ram  in  CHANNELS  per-channel read enable.
- Mout_we_ram  in  CHANNELS  per-channel write enable.
- Mout_addr_ram  in  CHANNELS*ADDR_W  channel c at [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  CHANNELS*DATA_W  write data per lane.
- Mout_data_ram_size  in  CHANNELS*SIZE_W  access width in bits per lane.
- Sout_Rdata_ram  in  CHANNELS*DATA_W  accelerator slave read data, ORed into M_Rdata_ram.
- Sout_DataRdy  in  CHANNELS  accelerator slave ready, ORed into M_DataRdy.
- init_we  in  1  preload write strobe.
- init_addr  in  ADDR_W  preload offset within window (0..MEMSIZE-1).
- init_data  in  DATA_W  preload byte.
- M_Rdata_ram  out  CHANNELS*DATA_W  read data to accelerator.
- M_DataRdy  out  CHANNELS  per-channel completion strobe.
- protocol_error  out  1  sticky: oe and we seen together on one channel.
- error_channel  out  CHANNELS  sticky per-channel error bits.

Behaviour:
- Reset (synchronous, active-high):
  - Clears lane counters, read pipelines, protocol_error and error_channel; M_Rdata_ram and M_DataRdy therefore equal the Sout_* inputs.
  - Memory contents are NOT cleared.
  - Any transaction in flight when reset asserts is dropped; no DataRdy is issued for it.
- In-range test per channel: hit_c = BASE_ADDR <= addr_c < BASE_ADDR+MEMSIZE, computed at ADDR_W+1 bits so the upper bound cannot wrap. Index = addr_c - BASE_ADDR.
- Lane counter cnt_c:
  - If oe_c & hit_c & !we_c: cnt_c <= (cnt_c < READ_DELAY-1) ? cnt_c+1 : 0.
  - Else if we_c & hit_c & !oe_c: same rule against WRITE_DELAY-1.
  - Else cnt_c <= 0.
- Ready: M_DataRdy[c] = Sout_DataRdy[c] | (hit_c & ((oe_c & cnt_c==READ_DELAY-1) | (we_c & cnt_c==WRITE_DELAY-1))), with oe_c and we_c exclusive.
- Holding oe beyond DataRdy starts a new access: cnt wraps to 0 the next cycle.
- Read data:
  - mem[index] (0 when !hit_c) enters a READ_DELAY-1 stage register pipeline.
  - M_Rdata_ram lane = pipe output | Sout lane.
  - With READ_DELAY=1 the path is combinational.
  - Result: data is valid in the DataRdy cycle.
- Write:
  - mask = (1<<size_c)-1, saturated to all ones for size_c >= DATA_W.
  - At each rising edge with we_c & hit_c & !oe_c: mem[index] <= (wdata & mask) | (mem[index] & ~mask).
  - The write commits on every cycle we is held, so it is idempotent.
- Simultaneous events:
  - Two channels write the same byte: the higher channel index wins.
  - Read and write to the same byte in the same cycle: the read samples the old value.
  - Bus write and init_we to the same byte: the bus write wins.
  - init_we to any other byte commits normally.
  - init_addr >= MEMSIZE is ignored.
- Protocol error: oe_c & we_c on the same cycle sets error_channel[c] and protocol_error, both sticky until reset. For that cycle the access is ignored: no write, cnt_c <= 0, no DataRdy.
- Out of range: no DataRdy, no write, read lane contributes 0.

Decomposition:
- Package ext_mem_pkg holds the default widths, delays, BASE_ADDR/MEMSIZE, and a function size_to_mask(size, DATA_W).
- Sub-module ext_mem_lane (one per channel via generate):
  - in-range test, cnt_c, DataRdy term, mask generation, read-delay pipeline, error detect.
- Memory array, write arbitration and init port stay in the top.

Test Plan:
- Preload mem[5]=0xA5; ch0 oe, addr 261 held 1 cycle -> M_DataRdy[0]=0 at t, 1 at t+1 with M_Rdata_ram[7:0]=0xA5; ch1 unaffected.
- mem[7]=0x30; ch1 we addr 263, wdata 0xFF, size 4 -> M_DataRdy[1]=1 same cycle; read-back returns 0x3F. Repeat with size 8 -> 0xFF.
- Both channels write addr 300 in the same cycle, ch0 0x11, ch1 0x22 -> mem[44]=0x22. Both read addr 300 next -> both lanes 0x22 after 2 cycles.
- ch0 oe addr 100 (below window) and addr 512 (above) -> no DataRdy, Rdata lane 0. Sout_DataRdy[0]=1 with Sout 0x5A -> M_DataRdy[0]=1, M_Rdata_ram[7:0]=0x5A.
- ch0 oe and we together at addr 270 -> protocol_error=1, error_channel=2'b01, mem[14] unchanged, no DataRdy. Flags stay set until reset.
- Reset asserted the cycle after ch0 oe -> no DataRdy afterwards, cnt=0. Memory still holds preloaded values on the next read.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg: shared widths, timing and write-mask helper for the external memory responder
package ext_mem_pkg;
  localparam int CHANNELS = 2;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int SIZE_W = 4;
  localparam int BASE_ADDR = 256;
  localparam int MEMSIZE = 256;
  localparam int READ_DELAY = 2;
  localparam int WRITE_DELAY = 1;
  localparam int IDX_W = $clog2(MEMSIZE);
  localparam int CNT_W = $clog2((READ_DELAY > WRITE_DELAY ? READ_DELAY : WRITE_DELAY) + 1);
  function automatic logic [DATA_W-1:0] size_to_mask(input logic [SIZE_W-1:0] size, input int data_w);
    logic [DATA_W:0] one_hot;
    one_hot = (DATA_W+1)'(1) << size;
    return int'(size) >= data_w ? '1 : one_hot[DATA_W-1:0] - DATA_W'(1);
  endfunction
endpackage

// File: rtl/ext_mem_responder_if.sv
// ext_mem_responder_if: accelerator master memory port, slave return path and responder replies
interface ext_mem_responder_if;
  import ext_mem_pkg::*;
  logic [CHANNELS-1:0] Mout_oe_ram;
  logic [CHANNELS-1:0] Mout_we_ram;
  logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
  logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
  logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram;
  logic [CHANNELS-1:0] Sout_DataRdy;
  logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
  logic [CHANNELS-1:0] M_DataRdy;
  modport master(
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy,
    input M_Rdata_ram, M_DataRdy
  );
  modport slave(
    input Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input Sout_Rdata_ram, Sout_DataRdy,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/ext_mem_lane.sv
// ext_mem_lane: per-channel window decode, latency counter, write mask, read pipeline and error flag
module ext_mem_lane
  import ext_mem_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic oe,
  input  logic we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [SIZE_W-1:0] size,
  input  logic [DATA_W-1:0] mem_byte,
  output logic [IDX_W-1:0] index,
  output logic wr_en,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] rdata,
  output logic rdy,
  output logic err
);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);
  localparam int PD = READ_DELAY > 1 ? READ_DELAY - 1 : 1;
  logic [ADDR_W:0] addr_x;
  logic hit, rd, wr, err_d, err_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [DATA_W-1:0] rd_in;
  logic [DATA_W-1:0] pipe_d [PD];
  logic [DATA_W-1:0] pipe_q [PD];
  always_comb begin
    addr_x = {1'b0, addr};
    hit = addr_x >= (ADDR_W+1)'(BASE_ADDR) && addr_x < (ADDR_W+1)'(BASE_ADDR + MEMSIZE);
    index = IDX_W'(addr - ADDR_W'(BASE_ADDR));
    rd = oe && !we && hit && !reset;
    wr = we && !oe && hit && !reset;
    cnt_d = rd ? (cnt_q < RD_LAST ? cnt_q + CNT_W'(1) : '0) : wr ? (cnt_q < WR_LAST ? cnt_q + CNT_W'(1) : '0) : '0;
    rdy = (rd && cnt_q == RD_LAST) || (wr && cnt_q == WR_LAST);
    wr_en = wr;
    mask = size_to_mask(size, DATA_W);
    err_d = err_q || (oe && we);
    err = err_q;
    rd_in = hit ? mem_byte : '0;
    pipe_d[0] = rd_in;
    for (int i = 1; i < PD; i++) pipe_d[i] = pipe_q[i-1];
    rdata = reset ? '0 : READ_DELAY > 1 ? pipe_q[PD-1] : rd_in;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      pipe_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      pipe_q <= pipe_d;
    end
  end
endmodule

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: byte-lane memory window answering the accelerator master port, ORed with its slave path
module ext_mem_responder
  import ext_mem_pkg::*;
(
  input  logic clock,
  input  logic reset,
  ext_mem_responder_if.slave bus,
  input  logic init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic protocol_error,
  output logic [CHANNELS-1:0] error_channel
);
  logic [DATA_W-1:0] mem_q [MEMSIZE];
  logic [DATA_W-1:0] mem_d [MEMSIZE];
  logic [IDX_W-1:0] index [CHANNELS];
  logic [DATA_W-1:0] mask [CHANNELS];
  logic [DATA_W-1:0] rdata [CHANNELS];
  logic [CHANNELS-1:0] wr_en, rdy;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    ext_mem_lane u_lane (
      .clock(clock),
      .reset(reset),
      .oe(bus.Mout_oe_ram[c]),
      .we(bus.Mout_we_ram[c]),
      .addr(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]),
      .size(bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]),
      .mem_byte(mem_q[index[c]]),
      .index(index[c]),
      .wr_en(wr_en[c]),
      .mask(mask[c]),
      .rdata(rdata[c]),
      .rdy(rdy[c]),
      .err(error_channel[c])
    );
    assign bus.M_Rdata_ram[c*DATA_W +: DATA_W] = rdata[c] | bus.Sout_Rdata_ram[c*DATA_W +: DATA_W];
    assign bus.M_DataRdy[c] = rdy[c] | bus.Sout_DataRdy[c];
  end
  assign protocol_error = |error_channel;
  always_comb begin
    mem_d = mem_q;
    if (init_we && init_addr < ADDR_W'(MEMSIZE)) mem_d[IDX_W'(init_addr)] = init_data;
    for (int i = 0; i < CHANNELS; i++)
      if (wr_en[i]) mem_d[index[i]] = (bus.Mout_Wdata_ram[i*DATA_W +: DATA_W] & mask[i]) | (mem_q[index[i]] & ~mask[i]);
  end
  always_ff @(posedge clock) mem_q <= mem_d;
endmodule
